pe_acc_seq: RTL and testbench
=============================

# pe_acc_seq

Sequencer for one processing element's accumulate-and-activate pass. On `start` it latches a job configuration, then consumes exactly `cfg_k` operand pairs over a valid/ready stream and multiply-accumulates them into a saturating W-bit accumulator. It then drives the result through ReLU (bypassable), rounding right-shift and DW-bit saturation, and holds it on a valid/ready output until accepted. One instance sits between the PE operand feeder and the output write-back buffer.

## Interface
Parameters:
- `W`, 24, accumulator width (signed)
- `DW`, 8, operand and output width (signed)
- `KW`, 10, width of the term-count field

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  job request; sampled only in IDLE
- `cfg_k`  in  KW  number of MAC terms; latched on the accepted `start`
- `cfg_shift`  in  5  right-shift amount, 0..W-1; latched on the accepted `start`
- `cfg_relu_en`  in  1  1 = apply ReLU; latched on the accepted `start`
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  high exactly while in ACC
- `a_in`, `b_in`  in  DW each  signed operands
- `out_valid`  out  1  high exactly while in OUT
- `out_ready`  in  1  consumer accepts the result
- `out_data`  out  DW  signed result
- `busy`  out  1  state != IDLE
- `done`  out  1  equals `out_valid & out_ready`

## Operation
State machine, encoding IDLE/ACC/OUT:
- IDLE, `start`=1 → clear accumulator, clear term counter, latch config. Next state is ACC if `cfg_k`!=0, otherwise OUT (result 0).
- ACC, on each input handshake (`in_valid & in_ready`): `acc <= sat_W(acc + sext(a_in*b_in))`.
  - Form the product in 2·DW bits and the sum in W+1 bits, then clamp to [-2^(W-1), 2^(W-1)-1].
  - Increment the counter; on the handshake that makes it reach `cfg_k` → OUT.
- OUT, `out_ready`=1 → IDLE.
- `start` outside IDLE is ignored.
- `in_valid` outside ACC is ignored; no operand is consumed.

Output datapath (combinational from the accumulator register and the latched config):
- Stage 1, `r`: equals `acc` if `cfg_relu_en`=0; otherwise `r = relu(acc)`, where negative values become 0.
- Stage 2, rounding shift:
  - `cfg_shift`=0: `s = r`.
  - Otherwise: `s = (r + 2^(cfg_shift-1)) >>> cfg_shift`, computed in W+1 bits (round half up).
- Stage 3: `out_data = clamp(s, -2^(DW-1), 2^(DW-1)-1)`.
- `out_data` is held stable throughout OUT. Its value outside OUT is don't-care.

## Timing
- Reset values, while `rst`=1:
  - state = IDLE; accumulator, counter and latched config = 0.
  - `in_ready`=0, `out_valid`=0, `busy`=0, `done`=0.
  - Consequently `out_data`=0.
- Reset asserted mid-job aborts immediately. No partial result is ever presented.
- Latency, with `start` sampled at edge 0 and `in_valid` held high:
  - `in_ready` is high in cycles 1..K, with one term consumed per cycle.
  - `out_valid` rises in cycle K+1.
  - For `cfg_k`=0, `out_valid` rises in cycle 1.
- Gaps in `in_valid` stretch the ACC phase cycle-for-cycle without changing the result.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data` is held and `in_ready`=0.
- OUT→IDLE takes one cycle. A new `start` can be accepted at the earliest one cycle after `done`.
- Maximum job length is 2^KW-1 terms.

## Structure
- Shared package `pe_pkg` holds:
  - the state enum `pe_seq_state_t`
  - functions `sat_signed` (generic clamp) and `round_shift`
- Sub-module: instantiate the existing `pe_relu` with `W` for stage 1. Its output is selected against `acc` by `cfg_relu_en`.
- Total RTL: roughly 150–250 lines.

## Test plan
Defaults: W=24, DW=8.
- Basic MAC:
  - Stimulus: K=3, a=(2,3,-1), b=(5,4,10), shift 0, relu 1, `in_valid` held high, `out_ready`=1.
  - Required: `out_data`=12; `out_valid` in cycle 4; `done` pulses once; `busy` low afterwards.
- ReLU on/off:
  - Stimulus: K=2, a=(-4,-5), b=(3,3), shift 0.
  - Required: with relu 1 → 0; with relu 0 → -27.
- Rounding and saturation:
  - K=1, a=127, b=127 (16129).
  - shift 8 → 63.
  - shift 6 → 252, clamped to 127.
  - shift 6, relu 0, a=-128, b=127 → -16256 shifts to -254, clamped to -128.
- Accumulator saturation:
  - Stimulus: K=600, every pair 127×127, shift 16.
  - Required: accumulator pins at 8388607; `out_data`=128 clamped to 127.
- Handshake stress:
  - Stimulus: K=4 with `in_valid` toggling 1,0,0,1,…; `out_ready` held low for 5 cycles; `start` pulsed during ACC and OUT.
  - Required: result identical to the gap-free run; `out_data` and `out_valid` stable during the stall; extra `start` pulses ignored; `in_ready`=0 in OUT.
- Reset and K=0:
  - Stimulus: `rst` asserted after 2 of 4 terms.
  - Required: all outputs 0 and state IDLE the same cycle; the next job (K=1, 3×3) returns 9.
  - Stimulus: job with K=0.
  - Required: `out_data`=0 with `out_valid` in cycle 1.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the processing-element sequencer.
// The helpers work on a 64-bit signed carrier; callers size the result back down.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } pe_seq_state_t;

    // Clamp x into the signed range of a 'bits'-wide value.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] x,
        input int                 bits
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Arithmetic right shift with round-half-up; a zero shift passes through.
    function automatic logic signed [63:0] round_shift(
        input logic signed [63:0] r,
        input logic        [4:0]  sh
    );
        if (sh == 5'd0) begin
            return r;
        end
        return (r + (64'sd1 <<< (sh - 5'd1))) >>> sh;
    endfunction

endpackage

// File: rtl/pe_acc_seq_if.sv
// Job, operand-stream and result-stream signals of the accumulate sequencer.
// The feeder/consumer side uses master; the sequencer uses slave.
interface pe_acc_seq_if #(
    parameter int DW = 8,
    parameter int KW = 10
);
    logic                 start;
    logic [KW-1:0]        cfg_k;
    logic [4:0]           cfg_shift;
    logic                 cfg_relu_en;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] a_in;
    logic signed [DW-1:0] b_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 busy;
    logic                 done;

    modport master (
        output start, cfg_k, cfg_shift, cfg_relu_en,
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, cfg_k, cfg_shift, cfg_relu_en,
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/pe_relu.sv
// Bitwise ReLU: every bit is masked off when the sign bit is set, so negatives become 0.
module pe_relu #(
    parameter int W = 24
) (
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign y[gi] = x[gi] & ~x[W-1];
        end
    endgenerate
endmodule

// File: rtl/pe_acc_seq.sv
// Accumulate-and-activate sequencer: latches a job, MACs cfg_k operand pairs into a
// saturating accumulator, then presents relu/round/clamp of the result until accepted.
module pe_acc_seq
    import pe_pkg::*;
#(
    parameter int W  = 24,
    parameter int DW = 8,
    parameter int KW = 10
) (
    input  logic         clk,
    input  logic         rst,
    pe_acc_seq_if.slave  bus
);

    pe_seq_state_t        state_reg, state_next;
    logic signed [W-1:0]  acc_reg, acc_next;
    logic [KW-1:0]        cnt_reg, cnt_next;
    logic [KW-1:0]        k_reg, k_next;
    logic [4:0]           shift_reg, shift_next;
    logic                 relu_reg, relu_next;

    logic signed [2*DW-1:0] prod;
    logic signed [W:0]      acc_sum;
    logic signed [W-1:0]    acc_sat;
    logic signed [W-1:0]    relu_out;
    logic signed [W-1:0]    r_val;

    // Full-precision product and one guard bit on the sum so the clamp sees true overflow.
    assign prod    = (2*DW)'(bus.a_in) * (2*DW)'(bus.b_in);
    assign acc_sum = (W+1)'(acc_reg) + (W+1)'(prod);
    assign acc_sat = W'(sat_signed(64'(acc_sum), W));

    pe_relu #(.W(W)) u_relu (
        .x (acc_reg),
        .y (relu_out)
    );

    assign r_val        = relu_reg ? relu_out : acc_reg;
    assign bus.out_data = DW'(sat_signed(round_shift(64'(r_val), shift_reg), DW));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            k_reg     <= '0;
            shift_reg <= '0;
            relu_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            k_reg     <= k_next;
            shift_reg <= shift_next;
            relu_reg  <= relu_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
        k_next        = k_reg;
        shift_next    = shift_reg;
        relu_next     = relu_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    k_next     = bus.cfg_k;
                    shift_next = bus.cfg_shift;
                    relu_next  = bus.cfg_relu_en;
                    // A zero-length job goes straight to presenting a zero result.
                    state_next = (bus.cfg_k != '0) ? ACC : OUT;
                end
            end
            ACC: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
                if (bus.in_valid) begin
                    acc_next = acc_sat;
                    cnt_next = cnt_reg + KW'(1);
                    if (cnt_next == k_reg) begin
                        state_next = OUT;
                    end
                end
            end
            OUT: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                bus.done      = bus.out_ready;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pe_acc_seq.sv
// Scenario bench for pe_acc_seq: expected results are queued per job and popped on accept.
module tb_pe_acc_seq;
    localparam int W  = 24;
    localparam int DW = 8;
    localparam int KW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   exp_q[$];

    logic signed [DW-1:0] op_a [0:1023];
    logic signed [DW-1:0] op_b [0:1023];

    pe_acc_seq_if #(.DW(DW), .KW(KW)) bus ();

    pe_acc_seq #(.W(W), .DW(DW), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL %s in_ready: got %b required 0", name, bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL %s out_valid: got %b required 0", name, bus.out_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL %s busy: got %b required 0", name, bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL %s done: got %b required 0", name, bus.done); end
        tests++; if (bus.out_data !== 8'sd0) begin fails++; $display("FAIL %s out_data: got %0d required 0", name, bus.out_data); end
    endtask

    // Runs one job; gaps gives in_valid pattern 1,0,0; stall holds out_ready low in OUT;
    // noise pulses start (with different config) during ACC and during the OUT stall.
    task automatic run_job(input string name, input int k, input int sh, input bit relu,
                           input bit gaps, input int stall, input bit noise, input int exp_cycle);
        int idx = 0;
        int cyc;
        int oc = 0;
        int dcnt = 0;
        int first_cyc = -1;
        int budget;
        int expv;
        bit got = 0;
        logic signed [DW-1:0] held = '0;
        logic signed [DW-1:0] expd;
        budget = 3 * k + stall + 20;
        bus.start       = 1'b1;
        bus.cfg_k       = KW'(k);
        bus.cfg_shift   = 5'(sh);
        bus.cfg_relu_en = relu;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (!got && cyc < budget) begin
            bus.in_valid  = (idx < k) && (!gaps || ((cyc - 1) % 3 == 0));
            bus.a_in      = op_a[idx[9:0]];
            bus.b_in      = op_b[idx[9:0]];
            bus.start     = noise && (cyc == 2 || (bus.out_valid && oc == 1));
            if (bus.start) begin
                bus.cfg_k       = 10'd7;
                bus.cfg_shift   = 5'd3;
                bus.cfg_relu_en = !relu;
            end
            bus.out_ready = bus.out_valid && (oc >= stall);
            #1;
            if (bus.done === 1'b1) dcnt++;
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid === 1'b1) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    held = bus.out_data;
                end else begin
                    tests++;
                    if (bus.out_data !== held) begin
                        fails++; $display("FAIL %s hold: out_data %0d changed from %0d", name, bus.out_data, held);
                    end
                end
                tests++;
                if (bus.in_ready !== 1'b0) begin
                    fails++; $display("FAIL %s in_ready_in_out: got %b required 0", name, bus.in_ready);
                end
                if (bus.out_ready) begin
                    got  = 1;
                    expv = exp_q.pop_front();
                    expd = DW'(expv);
                    $display("[TB] job %s k=%0d shift=%0d relu=%0d out_data=%0d expected=%0d cycle=%0d",
                             name, k, sh, relu, bus.out_data, expv, first_cyc);
                    tests++;
                    if (bus.out_data !== expd) begin
                        fails++; $display("FAIL %s out_data: got %0d required %0d", name, bus.out_data, expv);
                    end
                end
                oc++;
            end
            tick();
            cyc++;
        end
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s timeout: no result within %0d cycles", name, budget);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            tests++;
            if (first_cyc != exp_cycle) begin
                fails++; $display("FAIL %s latency: out_valid in cycle %0d required %0d", name, first_cyc, exp_cycle);
            end
            tests++;
            if (dcnt != 1) begin
                fails++; $display("FAIL %s done_pulses: got %0d required 1", name, dcnt);
            end
            tests++;
            if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
                fails++; $display("FAIL %s after_done: busy=%b out_valid=%b required 0,0", name, bus.busy, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_mac();
        op_a[0] = 8'sd2;  op_b[0] = 8'sd5;
        op_a[1] = 8'sd3;  op_b[1] = 8'sd4;
        op_a[2] = -8'sd1; op_b[2] = 8'sd10;
        exp_q.push_back(12);
        run_job("basic_mac", 3, 0, 1'b1, 1'b0, 0, 1'b0, 4);
    endtask

    task automatic test_relu();
        op_a[0] = -8'sd4; op_b[0] = 8'sd3;
        op_a[1] = -8'sd5; op_b[1] = 8'sd3;
        exp_q.push_back(0);
        run_job("relu_on", 2, 0, 1'b1, 1'b0, 0, 1'b0, 3);
        exp_q.push_back(-27);
        run_job("relu_off", 2, 0, 1'b0, 1'b0, 0, 1'b0, 3);
    endtask

    task automatic test_rounding();
        op_a[0] = 8'sd127; op_b[0] = 8'sd127;
        exp_q.push_back(63);
        run_job("round_sh8", 1, 8, 1'b1, 1'b0, 0, 1'b0, 2);
        exp_q.push_back(127);
        run_job("round_sh6_pos", 1, 6, 1'b1, 1'b0, 0, 1'b0, 2);
        op_a[0] = -8'sd128; op_b[0] = 8'sd127;
        exp_q.push_back(-128);
        run_job("round_sh6_neg", 1, 6, 1'b0, 1'b0, 0, 1'b0, 2);
    endtask

    task automatic test_acc_sat();
        for (int i = 0; i < 600; i++) begin
            op_a[i] = 8'sd127;
            op_b[i] = 8'sd127;
        end
        exp_q.push_back(127);
        run_job("acc_sat", 600, 16, 1'b0, 1'b0, 0, 1'b0, 601);
    endtask

    task automatic test_handshake_stress();
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 8'(i + 1);
            op_b[i] = 8'(i + 5);
        end
        exp_q.push_back(70);
        run_job("gap_free", 4, 0, 1'b0, 1'b0, 0, 1'b0, 5);
        exp_q.push_back(70);
        run_job("stress", 4, 0, 1'b0, 1'b1, 5, 1'b1, 11);
    endtask

    task automatic test_reset_abort();
        bus.start       = 1'b1;
        bus.cfg_k       = 10'd4;
        bus.cfg_shift   = 5'd0;
        bus.cfg_relu_en = 1'b0;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.a_in     = 8'sd5; bus.b_in = 8'sd5;
        tick();
        bus.a_in     = 8'sd6; bus.b_in = 8'sd6;
        tick();
        tests++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL abort_pre: busy=%b in_ready=%b required 1,1", bus.busy, bus.in_ready);
        end
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL abort_post: out_valid=%b busy=%b required 0,0", bus.out_valid, bus.busy);
        end
        op_a[0] = 8'sd3; op_b[0] = 8'sd3;
        exp_q.push_back(9);
        run_job("after_abort", 1, 0, 1'b0, 1'b0, 0, 1'b0, 2);
    endtask

    task automatic test_k_zero();
        exp_q.push_back(0);
        run_job("k_zero", 0, 3, 1'b0, 1'b0, 0, 1'b0, 1);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.cfg_k       = '0;
        bus.cfg_shift   = '0;
        bus.cfg_relu_en = 1'b0;
        bus.in_valid    = 1'b0;
        bus.a_in        = '0;
        bus.b_in        = '0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_basic_mac();
        test_relu();
        test_rounding();
        test_acc_sat();
        test_handshake_stress();
        test_reset_abort();
        test_k_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
